// File: rtl/io_pkg.sv
// Shared CPU IO map and KSTAT field layout; used by the KEY device and the CPU-side IO decoder.
package io_pkg;

    localparam int DBITS     = 32;
    localparam int KEY_WIDTH = 4;

    localparam logic [31:0] ADDR_HEX   = 32'hF000_0000;
    localparam logic [31:0] ADDR_LEDR  = 32'hF000_0004;
    localparam logic [31:0] ADDR_LEDG  = 32'hF000_0008;
    localparam logic [31:0] ADDR_KEY   = 32'hF000_0010;
    localparam logic [31:0] ADDR_SW    = 32'hF000_0014;
    localparam logic [31:0] ADDR_KSTAT = 32'hF000_0110;

    // KSTAT bit fields: EVT[3:0], OVR[7:4], IE[8]
    localparam int EVT_LO = 0;
    localparam int OVR_LO = 4;
    localparam int IE_BIT = 8;

    typedef enum logic [1:0] {
        SEL_NONE  = 2'd0,
        SEL_KDATA = 2'd1,
        SEL_KSTAT = 2'd2
    } key_sel_e;

endpackage

// File: rtl/key_debouncer.sv
// Purpose: 2-flop sync + stable-count debounce of one active-low button.
// Latency: level follows a raw edge after 2 + DEBOUNCE_CYCLES cycles; press pulses on the accepting cycle.
// Backpressure: none, free-running per key.
module key_debouncer #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_BITS        = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic key_raw,
    output logic level,
    output logic press
);

    logic                sync1, sync2;
    logic                synced;
    logic                mismatch;
    logic                at_thr;
    logic [CNT_BITS-1:0] cnt;

    // Synchroniser idles at 1 so a reset looks like "released".
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= key_raw;
            sync2 <= sync1;
        end
    end

    assign synced   = ~sync2;
    assign mismatch = (synced != level);
    assign at_thr   = (cnt == CNT_BITS'(DEBOUNCE_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (!mismatch) begin
            cnt <= '0;
        end else if (at_thr) begin
            level <= synced;
            cnt   <= '0;
        end else begin
            cnt <= cnt + CNT_BITS'(1);
        end
    end

    assign press = mismatch & at_thr & synced;

endmodule

// File: rtl/key_io_device.sv
// Purpose: memory-mapped KEY responder with sticky press events, overrun flags and irq.
// Latency: rdData/hit are combinational in the access cycle; register updates land on the next edge.
// Backpressure: none, every access completes in the cycle it is issued.
module key_io_device
    import io_pkg::*;
#(
    parameter int               DBITS           = io_pkg::DBITS,
    parameter int               KEY_WIDTH       = io_pkg::KEY_WIDTH,
    parameter logic [DBITS-1:0] ADDR_KDATA      = DBITS'(io_pkg::ADDR_KEY),
    parameter logic [DBITS-1:0] ADDR_KSTAT      = DBITS'(io_pkg::ADDR_KSTAT),
    parameter int               DEBOUNCE_CYCLES = 50000,
    parameter int               CNT_BITS        = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [KEY_WIDTH-1:0] KEY,
    input  logic [DBITS-1:0]     addr,
    input  logic [DBITS-1:0]     wrData,
    input  logic                 wrEn,
    input  logic                 rdEn,
    output logic [DBITS-1:0]     rdData,
    output logic                 hit,
    output logic                 irq
);

    logic [KEY_WIDTH-1:0] level, press;
    logic [KEY_WIDTH-1:0] evt, ovr;
    logic [KEY_WIDTH-1:0] clr_evt, clr_ovr, ovr_set;
    logic                 ie;
    logic                 wr_kstat;
    key_sel_e             sel;
    logic                 unused_wr;

    for (genvar i = 0; i < KEY_WIDTH; i++) begin : g_key
        key_debouncer #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_BITS        (CNT_BITS)
        ) u_deb (
            .clk     (clk),
            .reset   (reset),
            .key_raw (KEY[i]),
            .level   (level[i]),
            .press   (press[i])
        );
    end

    always_comb begin
        sel = SEL_NONE;
        if (addr == ADDR_KDATA)      sel = SEL_KDATA;
        else if (addr == ADDR_KSTAT) sel = SEL_KSTAT;
    end

    assign wr_kstat = wrEn && (sel == SEL_KSTAT);
    assign clr_evt  = wr_kstat ? wrData[EVT_LO +: KEY_WIDTH] : '0;
    assign clr_ovr  = wr_kstat ? wrData[OVR_LO +: KEY_WIDTH] : '0;
    // A press racing its own W1C re-arms EVT rather than counting as an overrun.
    assign ovr_set  = press & evt & ~clr_evt;
    assign unused_wr = ^wrData;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            evt <= '0;
            ovr <= '0;
            ie  <= 1'b0;
        end else begin
            evt <= (evt & ~clr_evt) | press;
            ovr <= (ovr & ~clr_ovr) | ovr_set;
            if (wr_kstat) ie <= wrData[IE_BIT];
        end
    end

    always_comb begin
        rdData = '0;
        if (!reset && rdEn) begin
            case (sel)
                SEL_KDATA: rdData[KEY_WIDTH-1:0] = level;
                SEL_KSTAT: begin
                    rdData[EVT_LO +: KEY_WIDTH] = evt;
                    rdData[OVR_LO +: KEY_WIDTH] = ovr;
                    rdData[IE_BIT]              = ie;
                end
                default: rdData = '0;
            endcase
        end
    end

    assign hit = !reset && (sel != SEL_NONE) && (rdEn || wrEn);
    assign irq = !reset && ie && (|evt);

endmodule
